// File: rtl/pll_pkg.sv
// PLL divider search: shared widths, limits
// and FSM state encoding.
package pll_pkg;

  localparam int DIVR_W = 4;
  localparam int DIVF_W = 7;
  localparam int DIVQ_W = 3;

  localparam int FIN_LO  = 10000;
  localparam int FIN_HI  = 133000;
  localparam int FREQ_LO = 16000;
  localparam int FREQ_HI = 275000;
  localparam int PFD_LO  = 10000;
  localparam int PFD_HI  = 133000;
  localparam int VCO_LO  = 533000;
  localparam int VCO_HI  = 1066000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_PFD,
    S_VCO,
    S_QLOOP,
    S_DONE
  } pll_state_t;

endpackage

// File: rtl/pll_udiv.sv
// Restoring unsigned divider, one quotient
// bit per cycle, FW cycles from start to done.
module pll_udiv #(
  parameter int FW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [FW-1:0] dividend,
  input  logic [FW-1:0] divisor,
  output logic          done,
  output logic [FW-1:0] quot
);

  localparam int CW = $clog2(FW + 1);

  logic [FW-1:0] rem;
  logic [CW-1:0] cnt;
  logic          run;
  logic [FW:0]   sh;
  logic [FW:0]   dif;

  // trial subtraction of the shifted remainder
  always_comb begin
    sh  = {rem, quot[FW-1]};
    dif = sh - {1'b0, divisor};
  end

  // shift/subtract iteration and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      rem  <= '0;
      quot <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= '0;
        quot <= dividend;
        cnt  <= CW'(FW);
        run  <= 1'b1;
      end else if (run) begin
        if (!dif[FW]) begin
          rem  <= dif[FW-1:0];
          quot <= {quot[FW-2:0], 1'b1};
        end else begin
          rem  <= sh[FW-1:0];
          quot <= {quot[FW-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pll_div_search.sv
// Exhaustive DIVR/DIVF/DIVQ search for the
// setting closest to a requested PLL output.
module pll_div_search
  import pll_pkg::*;
#(
  parameter int FW      = 24,
  parameter int PFD_MIN = PFD_LO,
  parameter int PFD_MAX = PFD_HI,
  parameter int VCO_MIN = VCO_LO,
  parameter int VCO_MAX = VCO_HI
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [FW-1:0]     f_in,
  input  logic [FW-1:0]     f_req,
  input  logic              simple_fb,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              range_err,
  output logic [DIVR_W-1:0] divr,
  output logic [DIVF_W-1:0] divf,
  output logic [DIVQ_W-1:0] divq,
  output logic [FW-1:0]     f_out,
  output logic [FW-1:0]     err
);

  localparam int AW = FW + DIVF_W + 6;

  localparam logic [AW-1:0] FIN_L = AW'(FIN_LO);
  localparam logic [AW-1:0] FIN_H = AW'(FIN_HI);
  localparam logic [AW-1:0] FRQ_L = AW'(FREQ_LO);
  localparam logic [AW-1:0] FRQ_H = AW'(FREQ_HI);
  localparam logic [AW-1:0] PFD_L = AW'(PFD_MIN);
  localparam logic [AW-1:0] PFD_H = AW'(PFD_MAX);
  localparam logic [AW-1:0] VCO_L = AW'(VCO_MIN);
  localparam logic [AW-1:0] VCO_H = AW'(VCO_MAX);

  pll_state_t state, state_n;

  logic [FW-1:0]     fin_q, freq_q;
  logic              simple_q, pend;
  logic [FW-1:0]     pfd;
  logic [AW-1:0]     acc;
  logic [DIVR_W-1:0] r_cur;
  logic [DIVF_W-1:0] f_cur;
  logic [DIVQ_W-1:0] q_cur;

  logic          div_go, div_done;
  logic [FW-1:0] div_q, dvs;

  logic launch, rerr_set, acc_init;
  logic f_step, r_step, q_inc, upd;
  logic adv_f, adv_r;

  logic [AW-1:0] c_fout, c_vco, c_err, frq_w;
  logic          c_ok, c_better;
  logic          fin_ok, frq_ok, pfd_ok;
  logic          last_f, last_r;

  assign dvs = FW'(r_cur) + FW'(r_step) + FW'(1);

  pll_udiv #(.FW(FW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_go),
    .dividend (fin_q),
    .divisor  (dvs),
    .done     (div_done),
    .quot     (div_q)
  );

  // candidate evaluation and range checks
  always_comb begin
    frq_w  = AW'(freq_q);
    c_fout = simple_q ? (acc >> q_cur) : acc;
    c_vco  = simple_q ? acc : (acc << q_cur);
    c_ok   = (c_vco >= VCO_L) && (c_vco <= VCO_H);
    c_err  = (c_fout > frq_w) ? (c_fout - frq_w)
                              : (frq_w - c_fout);
    c_better = c_ok && (!found || (c_err < AW'(err)));
    fin_ok = (AW'(fin_q) >= FIN_L) && (AW'(fin_q) <= FIN_H);
    frq_ok = (frq_w >= FRQ_L) && (frq_w <= FRQ_H);
    pfd_ok = (AW'(pfd) >= PFD_L) && (AW'(pfd) <= PFD_H);
    last_f = simple_q ? (&f_cur) : (f_cur == 7'd63);
    last_r = &r_cur;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // next state and datapath strobes
  always_comb begin
    state_n  = state;
    busy     = 1'b0;
    done     = 1'b0;
    launch   = 1'b0;
    rerr_set = 1'b0;
    div_go   = 1'b0;
    acc_init = 1'b0;
    f_step   = 1'b0;
    r_step   = 1'b0;
    q_inc    = 1'b0;
    upd      = 1'b0;
    adv_f    = 1'b0;
    adv_r    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start || pend) begin
          launch  = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (!fin_ok || !frq_ok) begin
          rerr_set = 1'b1;
          state_n  = S_DONE;
        end else begin
          div_go  = 1'b1;
          state_n = S_DIV;
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (div_done) state_n = S_PFD;
      end
      S_PFD: begin
        busy = 1'b1;
        if (pfd_ok) begin
          acc_init = 1'b1;
          state_n  = S_VCO;
        end else begin
          adv_r = 1'b1;
        end
      end
      S_VCO: begin
        busy = 1'b1;
        if (!simple_q)         state_n = S_QLOOP;
        else if (acc > VCO_H)  adv_r   = 1'b1;
        else if (acc >= VCO_L) state_n = S_QLOOP;
        else                   adv_f   = 1'b1;
      end
      S_QLOOP: begin
        busy = 1'b1;
        upd  = c_better;
        if (c_better && (c_err == '0))
          state_n = S_DONE;
        else if (q_cur == 3'd6)
          adv_f = 1'b1;
        else
          q_inc = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (adv_f) begin
      if (last_f) begin
        adv_r = 1'b1;
      end else begin
        f_step  = 1'b1;
        state_n = S_VCO;
      end
    end
    if (adv_r) begin
      if (last_r) begin
        state_n = S_DONE;
      end else begin
        r_step  = 1'b1;
        div_go  = 1'b1;
        state_n = S_DIV;
      end
    end
  end

  // a start seen during DONE launches the next search
  always_ff @(posedge clk) begin
    if (reset)
      pend <= 1'b0;
    else if (state == S_DONE && start)
      pend <= 1'b1;
    else if (state == S_IDLE)
      pend <= 1'b0;
  end

  // search datapath and best-result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fin_q     <= '0;
      freq_q    <= '0;
      simple_q  <= 1'b0;
      pfd       <= '0;
      acc       <= '0;
      r_cur     <= '0;
      f_cur     <= '0;
      q_cur     <= '0;
      found     <= 1'b0;
      range_err <= 1'b0;
      divr      <= '0;
      divf      <= '0;
      divq      <= '0;
      f_out     <= '0;
      err       <= '0;
    end else begin
      if (launch) begin
        fin_q     <= f_in;
        freq_q    <= f_req;
        simple_q  <= simple_fb;
        r_cur     <= '0;
        found     <= 1'b0;
        range_err <= 1'b0;
        divr      <= '0;
        divf      <= '0;
        divq      <= '0;
        f_out     <= '0;
        err       <= '0;
      end
      if (rerr_set) range_err <= 1'b1;
      if (state == S_DIV && div_done) pfd <= div_q;
      if (acc_init) begin
        acc   <= AW'(pfd);
        f_cur <= '0;
        q_cur <= 3'd1;
      end
      if (f_step) begin
        acc   <= acc + AW'(pfd);
        f_cur <= f_cur + 7'd1;
        q_cur <= 3'd1;
      end
      if (q_inc)  q_cur <= q_cur + 3'd1;
      if (r_step) r_cur <= r_cur + 4'd1;
      if (upd) begin
        found <= 1'b1;
        divr  <= r_cur;
        divf  <= f_cur;
        divq  <= q_cur;
        f_out <= FW'(c_fout);
        err   <= FW'(c_err);
      end
    end
  end

endmodule

// File: tb/tb_pll_div_search.sv
// Directed bench for pll_div_search: vector
// table plus hand-written multi-cycle sequences.
module tb_pll_div_search;

  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset, start, simple_fb;
  logic [23:0] f_in, f_req;
  logic        busy, done, found, range_err;
  logic [3:0]  divr;
  logic [6:0]  divf;
  logic [2:0]  divq;
  logic [23:0] f_out, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_div_search dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .f_in      (f_in),
    .f_req     (f_req),
    .simple_fb (simple_fb),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .range_err (range_err),
    .divr      (divr),
    .divf      (divf),
    .divq      (divq),
    .f_out     (f_out),
    .err       (err)
  );

  typedef struct {
    logic [23:0] fin;
    logic [23:0] frq;
    logic        smp;
    logic        rerr;
    logic        fnd;
    logic [3:0]  r;
    logic [6:0]  f;
    logic [2:0]  q;
    logic [23:0] fo;
    logic [23:0] er;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic launch(input logic [23:0] fi,
                        input logic [23:0] fr,
                        input logic sm);
    @(negedge clk);
    f_in      = fi;
    f_req     = fr;
    simple_fb = sm;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc,
                           output logic seen);
    cyc  = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end while (!seen && cyc < LIMIT);
  endtask

  initial begin
    int   cyc;
    logic seen;
    logic any_done;

    vt[0] = '{24'd16000, 24'd100000, 1'b1, 1'b0, 1'b1,
              4'd0, 7'd49, 3'd3, 24'd100000, 24'd0};
    vt[1] = '{24'd12000, 24'd48000, 1'b1, 1'b0, 1'b1,
              4'd0, 7'd63, 3'd4, 24'd48000, 24'd0};
    vt[2] = '{24'd16000, 24'd100000, 1'b0, 1'b0, 1'b1,
              4'd0, 7'd5, 3'd3, 24'd96000, 24'd4000};
    vt[3] = '{24'd20000, 24'd50000, 1'b1, 1'b0, 1'b1,
              4'd0, 7'd39, 3'd4, 24'd50000, 24'd0};
    vt[4] = '{24'd5000, 24'd100000, 1'b1, 1'b1, 1'b0,
              4'd0, 7'd0, 3'd0, 24'd0, 24'd0};
    vt[5] = '{24'd16000, 24'd300000, 1'b0, 1'b1, 1'b0,
              4'd0, 7'd0, 3'd0, 24'd0, 24'd0};

    reset     = 1'b1;
    start     = 1'b0;
    simple_fb = 1'b0;
    f_in      = '0;
    f_req     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_rerr", range_err, 0);
    check("rst_fout", f_out, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      repeat (2) @(negedge clk);
      launch(vt[i].fin, vt[i].frq, vt[i].smp);
      wait_done(cyc, seen);
      check($sformatf("v%0d_done", i), seen, 1);
      check($sformatf("v%0d_rerr", i),
            range_err, vt[i].rerr);
      check($sformatf("v%0d_found", i),
            found, vt[i].fnd);
      check($sformatf("v%0d_divr", i), divr, vt[i].r);
      check($sformatf("v%0d_divf", i), divf, vt[i].f);
      check($sformatf("v%0d_divq", i), divq, vt[i].q);
      check($sformatf("v%0d_fout", i), f_out, vt[i].fo);
      check($sformatf("v%0d_err", i), err, vt[i].er);
      if (vt[i].rerr)
        check($sformatf("v%0d_lat", i), cyc <= 3, 1);
    end

    // second start while busy is ignored
    repeat (2) @(negedge clk);
    launch(24'd16000, 24'd100000, 1'b1);
    @(negedge clk);
    check("bz_busy", busy, 1);
    repeat (10) @(negedge clk);
    f_in      = 24'd12000;
    f_req     = 24'd48000;
    simple_fb = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, seen);
    check("bz_done", seen, 1);
    check("bz_divf", divf, 49);
    check("bz_fout", f_out, 100000);
    repeat (4) @(negedge clk);
    check("bz_idle", busy, 0);

    // reset in the middle of a long search
    launch(24'd16000, 24'd100000, 1'b0);
    repeat (100) @(negedge clk);
    check("mr_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mr_busy0", busy, 0);
    check("mr_found", found, 0);
    check("mr_divf", divf, 0);
    check("mr_fout", f_out, 0);
    check("mr_err", err, 0);
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    check("mr_nodone", any_done, 0);

    // back-to-back searches, start during done
    repeat (2) @(negedge clk);
    launch(24'd16000, 24'd100000, 1'b1);
    wait_done(cyc, seen);
    check("bb1_done", seen, 1);
    check("bb1_divf", divf, 49);
    check("bb1_fout", f_out, 100000);
    f_in      = 24'd12000;
    f_req     = 24'd48000;
    simple_fb = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("bb_pulse", done, 0);
    wait_done(cyc, seen);
    check("bb2_done", seen, 1);
    check("bb2_divf", divf, 63);
    check("bb2_divq", divq, 4);
    check("bb2_fout", f_out, 48000);
    check("bb2_err", err, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/pll_div_search.md
PLL_DIV_SEARCH -- requirements
Module: pll_div_search

Interface
REQ-001 SHALL have parameter FW, default 24, meaning the frequency word width in kHz, unsigned.
REQ-002 SHALL have parameter PFD_MIN, default 10000, meaning the minimum PFD frequency in kHz.
REQ-003 SHALL have parameter PFD_MAX, default 133000, meaning the maximum PFD frequency in kHz.
REQ-004 SHALL have parameter VCO_MIN, default 533000, meaning the minimum VCO frequency in kHz.
REQ-005 SHALL have parameter VCO_MAX, default 1066000, meaning the maximum VCO frequency in kHz.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: request a search; sampled only in IDLE.
REQ-009 SHALL have port f_in, input, FW bits: PLL reference frequency in kHz.
REQ-010 SHALL have port f_req, input, FW bits: requested output frequency in kHz.
REQ-011 SHALL have port simple_fb, input, 1 bit: 1 selects SIMPLE feedback, 0 selects non-simple feedback.
REQ-012 SHALL have port busy, output, 1 bit: high while a search is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a search completes.
REQ-014 SHALL have port found, output, 1 bit: a legal setting exists.
REQ-015 SHALL have port range_err, output, 1 bit: f_in or f_req is outside the legal range.
REQ-016 SHALL have ports divr, divf and divq, outputs, 4, 7 and 3 bits: the best divider settings.
REQ-017 SHALL have ports f_out and err, outputs, FW bits each: best achieved frequency and |f_out - f_req|.

Function
REQ-018 SHALL implement the states IDLE, CHECK, DIV, PFD, VCO, QLOOP and DONE.
REQ-019 SHALL, on start in IDLE, latch f_in, f_req and simple_fb, clear the best registers, assert busy and go to CHECK.
REQ-020 SHALL, in CHECK, set range_err if f_in is outside 10000..133000 or f_req is outside 16000..275000, and in that case go to DONE with found=0.
REQ-021 SHALL, in DIV, compute pfd = f_in / (divr+1) by truncating integer division using pll_udiv, for divr from 0 to 15.
REQ-022 SHALL, in PFD, skip to the next divr if pfd is outside PFD_MIN..PFD_MAX; otherwise set acc = pfd (divf = 0).
REQ-023 SHALL, in SIMPLE mode, iterate divf from 0 to 127 with acc += pfd each step (no multiplier), giving vco = acc.
REQ-024 SHALL, in SIMPLE mode when vco is in VCO_MIN..VCO_MAX, evaluate fout = vco >> divq for divq = 1..6, one divq per cycle.
REQ-025 SHALL, in SIMPLE mode, abandon the remaining divf values for the current divr once acc > VCO_MAX.
REQ-026 SHALL, in non-simple mode, iterate divf from 0 to 63 and evaluate fout = acc and vco = acc << divq for divq = 1..6; a candidate is legal only if vco is in range.
REQ-027 SHALL replace the best setting only when |fout - f_req| < err, or when no setting has been found yet; on equal error the first candidate in divr, divf, divq order is kept.
REQ-028 SHALL terminate early to DONE when err == 0.
REQ-029 SHALL size internal arithmetic so that it cannot overflow for FW + 7 + 6 bits.
REQ-030 SHALL, in DONE, pulse done for one cycle, drop busy and return to IDLE; the result outputs hold until the next start.
REQ-031 SHALL ignore start while busy, and SHALL honour start asserted in the same cycle as done on the following IDLE cycle.
REQ-032 SHALL complete the worst case (16 divr × (FW + 128×7) cycles) with no stall.

Reset
REQ-033 SHALL, on reset, go to IDLE and force busy, done, found, range_err, divr, divf, divq, f_out and err to 0.
REQ-034 SHALL, on reset during a search, abort it with no done pulse.

Structure
REQ-035 SHALL place the state encoding, the frequency limits and the DIVR/DIVF/DIVQ widths in the shared package pll_pkg.
REQ-036 SHALL contain exactly one sub-module, pll_udiv: a 1-bit-per-cycle restoring divider with start and done, FW cycles.

Verification
REQ-037 SHALL check: f_in=16000, f_req=100000, simple_fb=1 -> divr=0, divf=49, divq=3, f_out=100000, err=0, found=1.
REQ-038 SHALL check: f_in=12000, f_req=48000, simple_fb=1 -> divr=0, divf=63, divq=4, err=0.
REQ-039 SHALL check: f_in=16000, f_req=100000, simple_fb=0 -> divr=0, divf=5, divq=3, f_out=96000, err=4000.
REQ-040 SHALL check: f_in=5000 -> done within 3 cycles, range_err=1, found=0.
REQ-041 SHALL check: a second start while busy has no effect, and reset mid-search gives all outputs 0 with no done pulse.
REQ-042 SHALL check: back-to-back starts with different f_req -> each done pulse carries its own result.
